// File: rtl/xor_stream_sequencer.sv
// ---------------------------------------------------------------------------
// xor_stream_sequencer
//
// Sequences a byte-wide XOR cipher over a stream of message bytes using a
// repeating multi-byte key. The key lives in a small register file that is
// loaded one byte at a time while idle. A start command latches the message
// length. Each accepted input byte is XORed with the key byte at a rotating
// index and presented on a registered valid/ready output. A one-cycle done
// pulse follows the handshake of the last output byte.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   key_wr     in   write key_byte into the next key slot (IDLE only)
//   key_byte   in   [7:0] key byte to write
//   key_clear  in   invalidate key, rewind write pointer (IDLE only)
//   key_valid  out  every key slot written since the last clear/reset
//   start      in   begin a message (sampled in IDLE only)
//   msg_len    in   [LEN_W-1:0] message length in bytes, latched on start
//   in_valid   in   in_byte is valid
//   in_ready   out  block accepts in_byte this cycle
//   in_byte    in   [7:0] plaintext/ciphertext byte
//   out_valid  out  out_byte is valid
//   out_ready  in   sink accepts out_byte
//   out_byte   out  [7:0] in_byte XOR key byte
//   abort      in   terminate the current message (RUN/DRAIN only)
//   busy       out  high in RUN or DRAIN
//   done       out  one-cycle pulse after the last output handshake
//   err        out  one-cycle pulse on start without a valid key
// ---------------------------------------------------------------------------
module xor_stream_sequencer #(
  parameter int KEY_BYTES = 4,
  parameter int LEN_W     = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_wr,
  input  logic [7:0]       key_byte,
  input  logic             key_clear,
  output logic             key_valid,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [7:0]       r_keyMem [KEY_BYTES];
  logic [IDX_W-1:0] r_wptr;
  logic             r_keyValid;
  logic [IDX_W-1:0] r_kidx;
  logic [LEN_W-1:0] r_remaining;
  logic             r_outValid;
  logic [7:0]       r_outByte;
  logic             r_done;
  logic             r_err;

  logic             w_inReady;
  logic             w_inHs;
  logic             w_outHs;
  logic             w_lastIn;

  // The single output register can take a new byte whenever it is empty or
  // is being emptied in the same cycle, which gives full throughput.
  assign w_inReady = (r_state == RUN) && (!r_outValid || out_ready);
  // The remaining!=0 term keeps the counter from ever wrapping below zero.
  assign w_inHs    = in_valid && w_inReady && (r_remaining != '0);
  assign w_outHs   = r_outValid && out_ready;
  assign w_lastIn  = w_inHs && (r_remaining == LEN_W'(1));

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Abort wins over any handshake in the same cycle; a
  // start with no key or a zero length never leaves IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start && r_keyValid && (msg_len != '0)) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_lastIn) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || w_outHs) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Key register file. Writes and clears are only honoured while idle so a
  // message in flight always sees a stable key. Clear only rewinds the
  // pointer and drops key_valid; the stored bytes are left in place.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KEY_BYTES; i++) begin
        r_keyMem[i] <= 8'h00;
      end
      r_wptr     <= '0;
      r_keyValid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (key_clear) begin
        r_wptr     <= '0;
        r_keyValid <= 1'b0;
      end else if (key_wr) begin
        r_keyMem[r_wptr] <= key_byte;
        if (r_wptr == LAST_IDX) begin
          r_wptr     <= '0;
          r_keyValid <= 1'b1;
        end else begin
          r_wptr <= r_wptr + IDX_W'(1);
        end
      end
    end
  end

  // Datapath, length counter and status pulses. done/err default low every
  // cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_kidx      <= '0;
      r_remaining <= '0;
      r_outValid  <= 1'b0;
      r_outByte   <= 8'h00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (!r_keyValid) begin
              r_err <= 1'b1;
            end else if (msg_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= msg_len;
              r_kidx      <= '0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_outValid <= 1'b0;
          end else if (w_inHs) begin
            r_outByte   <= in_byte ^ r_keyMem[r_kidx];
            r_outValid  <= 1'b1;
            r_kidx      <= (r_kidx == LAST_IDX) ? '0 : r_kidx + IDX_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
          end else if (w_outHs) begin
            r_outValid <= 1'b0;
          end
        end
        DRAIN: begin
          if (abort) begin
            r_outValid <= 1'b0;
          end else if (w_outHs) begin
            r_outValid <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign key_valid = r_keyValid;
  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign out_byte  = r_outByte;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_xor_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_sequencer
//
// Directed bench for xor_stream_sequencer with KEY_BYTES=4. Message vectors
// and their hand-computed ciphertext live in a struct table; multi-cycle
// corner cases (backpressure, abort, reset mid-message) are written out as
// explicit sequences.
// ---------------------------------------------------------------------------
module tb_xor_stream_sequencer;

  typedef struct {
    logic [7:0] inByte;
    logic [7:0] expOut;
  } vec_t;

  logic        CLOCK_50;
  logic        reset;
  logic        key_wr;
  logic [7:0]  key_byte;
  logic        key_clear;
  logic        key_valid;
  logic        start;
  logic [15:0] msg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  vec_t       vecs [9];
  logic [7:0] keyTable [4];

  xor_stream_sequencer #(
    .KEY_BYTES(4),
    .LEN_W(16)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_wr   (key_wr),
    .key_byte (key_byte),
    .key_clear(key_clear),
    .key_valid(key_valid),
    .start    (start),
    .msg_len  (msg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // 50 MHz-style free-running clock.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  // Clock the currently driven inputs in, then settle just after the edge.
  task automatic applyStimulus();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Load the four-byte key, checking key_valid rises only after the last write.
  task automatic loadKey();
    for (int i = 0; i < 4; i++) begin
      key_wr   = 1'b1;
      key_byte = keyTable[i];
      applyStimulus();
      key_wr = 1'b0;
      checkOutput($sformatf("key_valid after write %0d", i), 16'(key_valid),
                  (i == 3) ? 16'd1 : 16'd0);
    end
  endtask

  // Issue start with the given length and leave start low afterwards.
  task automatic startMessage(input logic [15:0] len);
    start   = 1'b1;
    msg_len = len;
    applyStimulus();
    start = 1'b0;
  endtask

  // Stream table entries [first, first+count) with out_ready held high and
  // check every output, the drain cycle and the done pulse.
  task automatic runTable(input int first, input int count, input string tag);
    startMessage(16'(count));
    checkOutput({tag, " busy"}, 16'(busy), 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_byte  = vecs[first + i].inByte;
      #1;
      checkOutput($sformatf("%s in_ready %0d", tag, i), 16'(in_ready), 16'd1);
      applyStimulus();
      checkOutput($sformatf("%s out_valid %0d", tag, i), 16'(out_valid), 16'd1);
      checkOutput($sformatf("%s out_byte %0d", tag, i), 16'(out_byte),
                  16'(vecs[first + i].expOut));
      checkOutput($sformatf("%s done early %0d", tag, i), 16'(done), 16'd0);
    end
    in_valid = 1'b0;
    checkOutput({tag, " drain in_ready"}, 16'(in_ready), 16'd0);
    applyStimulus();
    checkOutput({tag, " done"}, 16'(done), 16'd1);
    checkOutput({tag, " out_valid cleared"}, 16'(out_valid), 16'd0);
    checkOutput({tag, " busy cleared"}, 16'(busy), 16'd0);
    applyStimulus();
    checkOutput({tag, " done pulse width"}, 16'(done), 16'd0);
  endtask

  initial begin
    // Key 55 AA 0F F0; message A and an all-zero message that exposes the key.
    keyTable[0] = 8'h55; keyTable[1] = 8'hAA;
    keyTable[2] = 8'h0F; keyTable[3] = 8'hF0;
    vecs[0] = '{8'h00, 8'h55};
    vecs[1] = '{8'hFF, 8'h55};
    vecs[2] = '{8'h12, 8'h1D};
    vecs[3] = '{8'h34, 8'hC4};
    vecs[4] = '{8'h56, 8'h03};
    vecs[5] = '{8'h00, 8'h55};
    vecs[6] = '{8'h00, 8'hAA};
    vecs[7] = '{8'h00, 8'h0F};
    vecs[8] = '{8'h00, 8'hF0};

    reset = 1'b1; key_wr = 1'b0; key_byte = 8'h00; key_clear = 1'b0;
    start = 1'b0; msg_len = 16'd0; in_valid = 1'b0; in_byte = 8'h00;
    out_ready = 1'b0; abort = 1'b0;

    // Reset state.
    applyStimulus();
    applyStimulus();
    checkOutput("rst key_valid", 16'(key_valid), 16'd0);
    checkOutput("rst in_ready", 16'(in_ready), 16'd0);
    checkOutput("rst out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst out_byte", 16'(out_byte), 16'h00);
    checkOutput("rst busy", 16'(busy), 16'd0);
    checkOutput("rst done", 16'(done), 16'd0);
    checkOutput("rst err", 16'(err), 16'd0);
    reset = 1'b0;
    applyStimulus();

    // Key load then a full-throughput message.
    loadKey();
    runTable(0, 5, "msgA");

    // Backpressure: sink stalls for 3 cycles after the 2nd output.
    startMessage(16'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_byte  = vecs[i].inByte;
      applyStimulus();
    end
    checkOutput("bp 2nd out_byte", 16'(out_byte), 16'h55);
    out_ready = 1'b0;
    in_byte   = vecs[2].inByte;
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput($sformatf("bp stall in_ready %0d", s), 16'(in_ready), 16'd0);
      applyStimulus();
      checkOutput($sformatf("bp stall out_valid %0d", s), 16'(out_valid), 16'd1);
      checkOutput($sformatf("bp stall out_byte %0d", s), 16'(out_byte), 16'h55);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 5; i++) begin
      in_byte = vecs[i].inByte;
      #1;
      checkOutput($sformatf("bp in_ready %0d", i), 16'(in_ready), 16'd1);
      applyStimulus();
      checkOutput($sformatf("bp out_byte %0d", i), 16'(out_byte), 16'(vecs[i].expOut));
    end
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("bp done", 16'(done), 16'd1);
    applyStimulus();

    // Start with the key invalidated.
    key_clear = 1'b1;
    applyStimulus();
    key_clear = 1'b0;
    checkOutput("clear key_valid", 16'(key_valid), 16'd0);
    startMessage(16'd5);
    checkOutput("nokey err", 16'(err), 16'd1);
    checkOutput("nokey busy", 16'(busy), 16'd0);
    checkOutput("nokey in_ready", 16'(in_ready), 16'd0);
    applyStimulus();
    checkOutput("nokey err pulse width", 16'(err), 16'd0);

    // Zero-length message with a valid key.
    loadKey();
    in_valid = 1'b1;
    in_byte  = 8'h77;
    startMessage(16'd0);
    checkOutput("len0 done", 16'(done), 16'd1);
    checkOutput("len0 busy", 16'(busy), 16'd0);
    checkOutput("len0 in_ready", 16'(in_ready), 16'd0);
    checkOutput("len0 out_valid", 16'(out_valid), 16'd0);
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("len0 done pulse width", 16'(done), 16'd0);

    // Abort after two outputs.
    startMessage(16'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_byte  = vecs[i].inByte;
      applyStimulus();
      checkOutput($sformatf("abort pre out_byte %0d", i), 16'(out_byte), 16'(vecs[i].expOut));
    end
    in_valid = 1'b0;
    abort    = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("abort busy", 16'(busy), 16'd0);
    checkOutput("abort out_valid", 16'(out_valid), 16'd0);
    checkOutput("abort in_ready", 16'(in_ready), 16'd0);
    checkOutput("abort done", 16'(done), 16'd0);
    checkOutput("abort key_valid", 16'(key_valid), 16'd1);
    applyStimulus();
    checkOutput("abort no late done", 16'(done), 16'd0);

    // One-byte message after abort, with key_wr attempted during RUN/DRAIN.
    startMessage(16'd1);
    key_wr   = 1'b1;
    key_byte = 8'h99;
    in_valid = 1'b1;
    in_byte  = 8'h00;
    applyStimulus();
    checkOutput("restart out_byte", 16'(out_byte), 16'h55);
    in_valid = 1'b0;
    applyStimulus();
    key_wr = 1'b0;
    checkOutput("restart done", 16'(done), 16'd1);
    applyStimulus();

    // Zero message reveals the key is unchanged by the RUN-time writes.
    runTable(5, 4, "keychk");

    // Reset asserted mid-RUN, between clock edges.
    startMessage(16'd5);
    in_valid = 1'b1;
    in_byte  = vecs[0].inByte;
    applyStimulus();
    checkOutput("midrst pre out_valid", 16'(out_valid), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrst out_byte", 16'(out_byte), 16'h00);
    checkOutput("midrst busy", 16'(busy), 16'd0);
    checkOutput("midrst in_ready", 16'(in_ready), 16'd0);
    checkOutput("midrst key_valid", 16'(key_valid), 16'd0);
    in_valid = 1'b0;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    startMessage(16'd5);
    checkOutput("postrst err", 16'(err), 16'd1);
    checkOutput("postrst busy", 16'(busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_sequencer.md
Name: xor_stream_sequencer

Overview:
- Sequences the byte-wide XOR cipher datapath over a stream of message bytes, using a multi-byte repeating key.
- Holds a small key register file loaded one byte at a time.
- On start, accepts msg_len bytes on a valid/ready input and XORs each byte with the key byte at a rotating index.
- Presents results on a registered valid/ready output and pulses done after the last byte leaves.
- Sits between the switch/host byte source and the LED/sink side of the cipher library.

Parameters:
KEY_BYTES, 4, key length in bytes; legal range 1..16.
LEN_W, 16, width of the message length field.

Ports:
CLOCK_50  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
key_wr  input  1  write key_byte into the next key slot.
key_byte  input  8  key byte to write.
key_clear  input  1  invalidate the key and reset the write pointer.
key_valid  output  1  all KEY_BYTES slots written since the last clear/reset.
start  input  1  begin a message; sampled in IDLE only.
msg_len  input  LEN_W  message length in bytes, latched on start.
in_valid  input  1  in_byte is valid.
in_ready  output  1  block accepts in_byte this cycle.
in_byte  input  8  plaintext/ciphertext byte.
out_valid  output  1  out_byte is valid.
out_ready  input  1  sink accepts out_byte.
out_byte  output  8  in_byte XOR key byte.
abort  input  1  terminate the current message.
busy  output  1  high in RUN or DRAIN.
done  output  1  one-cycle pulse after the last output handshake.
err  output  1  one-cycle pulse on start with key_valid=0.

Behaviour:
- Reset (asynchronous): FSM=IDLE; key_mem all 0; wptr=0; kidx=0; remaining=0; key_valid=0; in_ready=0; out_valid=0; out_byte=0x00; busy=0; done=0; err=0.
- FSM states: IDLE, RUN, DRAIN.
- Key load (IDLE only; key_wr ignored in RUN/DRAIN):
  - key_wr writes key_mem[wptr].
  - wptr increments and wraps to 0 after slot KEY_BYTES-1.
  - The write to slot KEY_BYTES-1 sets key_valid next cycle.
  - Further writes overwrite slots circularly; key_valid stays 1.
  - key_clear (IDLE only): wptr=0, key_valid=0; key_mem contents untouched. key_clear has priority over a simultaneous key_wr.
- Start handling (IDLE, start=1):
  - key_valid=0: err pulses next cycle; stay IDLE.
  - msg_len=0 (with key_valid=1): done pulses next cycle; stay IDLE; no data accepted.
  - Otherwise: latch remaining=msg_len, kidx=0, go RUN. busy=1 from the next cycle.
- start while busy is ignored.
- RUN datapath:
  - in_ready = !out_valid || out_ready (single output register, full throughput).
  - Input handshake = in_valid && in_ready.
  - On a handshake: out_byte <= in_byte ^ key_mem[kidx]; out_valid <= 1; kidx <= (kidx==KEY_BYTES-1) ? 0 : kidx+1; remaining decrements.
  - Latency is 1 cycle from input handshake to out_valid.
- Accepting the byte with remaining==1 moves the FSM to DRAIN.
- DRAIN:
  - in_ready=0.
  - On the out_valid && out_ready handshake: out_valid <= 0, done pulses next cycle, go IDLE.
- Output rules: out_valid and out_byte are held stable until out_ready. out_valid falls when out_ready is sampled with no new input handshake in the same cycle.
- kidx restarts at 0 for every message; the key stream is not continued across messages.
- abort (RUN/DRAIN): next cycle FSM=IDLE, out_valid=0, in_ready=0, no done pulse. Key and key_valid are retained. abort is ignored in IDLE.
- Reset mid-message: immediate return to the reset state; the key is lost.
- All arithmetic is unsigned; remaining never underflows.

Test Plan:
- Use KEY_BYTES=4.
- Key load: key_wr 0x55,0xAA,0x0F,0xF0 -> key_valid=1 after the 4th write; start with msg_len=5, stream 0x00,0xFF,0x12,0x34,0x56 with out_ready=1 -> out 0x55,0x55,0x1D,0xC4,0x03 on consecutive cycles, 1-cycle latency, one done pulse after the 5th output.
- Backpressure: same message with out_ready low for 3 cycles after the 2nd output -> in_ready=0 while out_valid&&!out_ready, out_byte held at 0x55, no byte lost or duplicated, same 5 outputs.
- Start after key_clear (key_valid=0) -> err pulse, busy stays 0, in_ready=0. msg_len=0 with a valid key -> done pulse only, no data accepted.
- Abort after 2 outputs of msg_len=5 -> IDLE next cycle, no done; a new message of 0x00 -> 0x55, confirming kidx restarted at 0.
- Reset asserted mid-RUN -> all outputs zero asynchronously, key_valid=0; key_wr during RUN -> key_mem unchanged (verified by the next message's outputs).
